// File: rtl/punc_control_pkg.sv
// punc_control_pkg: shared definitions for the PUnC control unit.
//   - LC3 opcode constants
//   - FSM state encoding
//   - select encodings for the memory read-address mux and the RF write-data mux
//   - ALU function codes and one-hot sign-extension selects
//   - ctrl_t: the full control vector produced by punc_ctrl_decode
//   - exec_next(): successor of the EXEC state for a given opcode
// Optional feature macro: PUNC_INDIRECT_EN (enables LDI/STI via EXEC2).
package punc_control_pkg;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_CCUPD  = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] MEM_PC     = 3'd0;
  localparam logic [2:0] MEM_PC_OFF = 3'd1;
  localparam logic [2:0] MEM_IND    = 3'd2;
  localparam logic [2:0] MEM_MDATA  = 3'd3;
  localparam logic [2:0] MEM_ALU    = 3'd4;

  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_PC     = 2'd1;
  localparam logic [1:0] WD_MEM    = 2'd2;
  localparam logic [1:0] WD_PC_OFF = 2'd3;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_NOT  = 2'd3;

  localparam logic [3:0] SEXT_IMM5  = 4'b1000;
  localparam logic [3:0] SEXT_OFF6  = 4'b0100;
  localparam logic [3:0] SEXT_OFF9  = 4'b0010;
  localparam logic [3:0] SEXT_OFF11 = 4'b0001;

  typedef struct packed {
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_sti;
    logic        str;
    logic [2:0]  rf_wr_addr;
    logic        rf_wr_en;
    logic [2:0]  rf_r_addr_0;
    logic [2:0]  rf_r_addr_1;
    logic [1:0]  rf_w_data_sel;
    logic        ir_ld;
    logic        jmp_ret_jsrr;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic [2:0]  nzp;
    logic [3:0]  sext_sel;
    logic        halted;
    logic [10:0] const_n;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Loads need a second pass to set the condition codes from the loaded
  // register; indirect ops need EXEC2 for the second memory access.
  function automatic state_t exec_next(input logic [3:0] op);
    state_t nxt;
    nxt = S_FETCH;
    case (op)
      OP_LD, OP_LDR: nxt = S_CCUPD;
`ifdef PUNC_INDIRECT_EN
      OP_LDI, OP_STI: nxt = S_EXEC2;
`endif
      OP_TRAP: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// punc_ctrl_decode: purely combinational control decode for PUnC.
// Ports:
//   state  in  3      current FSM state (state_t encoding)
//   ir     in  16     current instruction
//   ctrl   out CTRL_W packed ctrl_t control vector
// Optional feature macro: PUNC_INDIRECT_EN (LDI/STI decode in EXEC/EXEC2;
// otherwise they decode as NOPs).
module punc_ctrl_decode
  import punc_control_pkg::*;
(
  input  logic [2:0]        state,
  input  logic [15:0]       ir,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t      c;
  logic [3:0] op;
  logic [2:0] dr;
  logic [2:0] sr;

  assign op = ir[15:12];
  assign dr = ir[11:9];
  assign sr = ir[8:6];

  always_comb begin
    c         = '0;
    c.const_n = ir[10:0];
    case (state_t'(state))
      S_INIT:  c.pc_clr = 1'b1;
      S_FETCH: begin
        c.mem_r_addr_sel = MEM_PC;
        c.ir_ld          = 1'b1;
        c.pc_up          = 1'b1;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_AND: begin
            c.rf_r_addr_0   = sr;
            c.rf_r_addr_1   = ir[2:0];
            c.add_const     = ir[5];
            c.sext_sel      = SEXT_IMM5;
            c.alu_sel       = (op == OP_ADD) ? ALU_ADD : ALU_AND;
            c.rf_wr_addr    = dr;
            c.rf_wr_en      = 1'b1;
            c.rf_w_data_sel = WD_ALU;
            c.cc_en         = 1'b1;
          end
          OP_NOT: begin
            c.rf_r_addr_0   = sr;
            c.alu_sel       = ALU_NOT;
            c.rf_wr_addr    = dr;
            c.rf_wr_en      = 1'b1;
            c.rf_w_data_sel = WD_ALU;
            c.cc_en         = 1'b1;
          end
          OP_BR: begin
            // The datapath compares this mask with its N/Z/P flags.
            c.nzp      = ir[11:9];
            c.sext_sel = SEXT_OFF9;
          end
          OP_JMP: begin
            c.rf_r_addr_0  = sr;
            c.alu_sel      = ALU_PASS;
            c.jmp_ret_jsrr = 1'b1;
            c.pc_ld        = 1'b1;
          end
          OP_JSR: begin
            // For JSRR R7 the PC takes the old R7 through the ALU while R7
            // captures the return address on the same edge.
            c.rf_wr_addr    = 3'd7;
            c.rf_wr_en      = 1'b1;
            c.rf_w_data_sel = WD_PC;
            c.pc_ld         = 1'b1;
            if (ir[11]) begin
              c.sext_sel = SEXT_OFF11;
            end else begin
              c.jmp_ret_jsrr = 1'b1;
              c.rf_r_addr_0  = sr;
              c.alu_sel      = ALU_PASS;
            end
          end
          OP_LD: begin
            c.mem_r_addr_sel = MEM_PC_OFF;
            c.sext_sel       = SEXT_OFF9;
            c.rf_wr_addr     = dr;
            c.rf_wr_en       = 1'b1;
            c.rf_w_data_sel  = WD_MEM;
          end
          OP_LDR: begin
            c.mem_r_addr_sel = MEM_ALU;
            c.rf_r_addr_0    = sr;
            c.alu_sel        = ALU_ADD;
            c.add_const      = 1'b1;
            c.sext_sel       = SEXT_OFF6;
            c.rf_wr_addr     = dr;
            c.rf_wr_en       = 1'b1;
            c.rf_w_data_sel  = WD_MEM;
          end
`ifdef PUNC_INDIRECT_EN
          OP_LDI, OP_STI: begin
            // First access fetches the pointer into the indirect latch.
            c.mem_r_addr_sel = MEM_PC_OFF;
            c.sext_sel       = SEXT_OFF9;
          end
`endif
          OP_LEA: begin
            c.sext_sel      = SEXT_OFF9;
            c.rf_wr_addr    = dr;
            c.rf_wr_en      = 1'b1;
            c.rf_w_data_sel = WD_PC_OFF;
          end
          OP_ST: begin
            c.rf_r_addr_0 = dr;
            c.alu_sel     = ALU_PASS;
            c.sext_sel    = SEXT_OFF9;
            c.mem_wr_en   = 1'b1;
          end
          OP_STR: begin
            c.str         = 1'b1;
            c.rf_r_addr_0 = sr;
            c.rf_r_addr_1 = dr;
            c.alu_sel     = ALU_ADD;
            c.add_const   = 1'b1;
            c.sext_sel    = SEXT_OFF6;
            c.mem_wr_en   = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef PUNC_INDIRECT_EN
      S_EXEC2: begin
        if (op == OP_LDI) begin
          c.mem_r_addr_sel = MEM_IND;
          c.rf_wr_addr     = dr;
          c.rf_wr_en       = 1'b1;
          c.rf_w_data_sel  = WD_MEM;
        end else if (op == OP_STI) begin
          c.state2_sti  = 1'b1;
          c.rf_r_addr_0 = dr;
          c.alu_sel     = ALU_PASS;
          c.mem_wr_en   = 1'b1;
        end
      end
`endif
      S_CCUPD: begin
        // Re-read the loaded register through the ALU so the flags follow it.
        c.rf_r_addr_0 = dr;
        c.alu_sel     = ALU_PASS;
        c.cc_en       = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/punc_control.sv
// punc_control: fetch/decode/execute sequencer for the PUnC LC3 datapath.
// Ports:
//   clk, rst (synchronous, active-high)      ir: current instruction
//   mem_wr_en, mem_r_addr_sel, state2_STI, STR       memory controls
//   RF_wr_addr, RF_wr_en, RF_r_addr_0/1, RF_w_data_sel  register file
//   ir_ld, JMP_RET_JSRR, pc_ld, pc_clr, pc_up        IR / PC controls
//   add_const, alu_sel, cc_en, n, z, p               ALU / condition codes
//   const_n (= ir[10:0]), SEXT_Select, halted
// Outputs are a combinational decode of state and ir; while rst is high
// they are forced to pc_clr only, cancelling any pending write.
// Optional feature macro: PUNC_INDIRECT_EN (LDI/STI through EXEC2).
module punc_control
  import punc_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        mem_wr_en,
  output logic [2:0]  mem_r_addr_sel,
  output logic        state2_STI,
  output logic        STR,
  output logic [2:0]  RF_wr_addr,
  output logic        RF_wr_en,
  output logic [2:0]  RF_r_addr_0,
  output logic [2:0]  RF_r_addr_1,
  output logic [1:0]  RF_w_data_sel,
  output logic        ir_ld,
  output logic        JMP_RET_JSRR,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        add_const,
  output logic [1:0]  alu_sel,
  output logic        cc_en,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [10:0] const_n,
  output logic [3:0]  SEXT_Select,
  output logic        halted
);

  state_t            state;
  logic [CTRL_W-1:0] dec_vec;
  ctrl_t             dec;
  ctrl_t             ctl;

  punc_ctrl_decode u_decode (
    .state (state),
    .ir    (ir),
    .ctrl  (dec_vec)
  );

  assign dec = dec_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC:   state <= exec_next(ir[15:12]);
`ifdef PUNC_INDIRECT_EN
        S_EXEC2:  state <= (ir[15:12] == OP_LDI) ? S_CCUPD : S_FETCH;
`endif
        S_CCUPD:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    ctl = dec;
    if (rst) begin
      ctl         = '0;
      ctl.pc_clr  = 1'b1;
      ctl.const_n = dec.const_n;
    end
  end

  assign mem_wr_en      = ctl.mem_wr_en;
  assign mem_r_addr_sel = ctl.mem_r_addr_sel;
  assign state2_STI     = ctl.state2_sti;
  assign STR            = ctl.str;
  assign RF_wr_addr     = ctl.rf_wr_addr;
  assign RF_wr_en       = ctl.rf_wr_en;
  assign RF_r_addr_0    = ctl.rf_r_addr_0;
  assign RF_r_addr_1    = ctl.rf_r_addr_1;
  assign RF_w_data_sel  = ctl.rf_w_data_sel;
  assign ir_ld          = ctl.ir_ld;
  assign JMP_RET_JSRR   = ctl.jmp_ret_jsrr;
  assign pc_ld          = ctl.pc_ld;
  assign pc_clr         = ctl.pc_clr;
  assign pc_up          = ctl.pc_up;
  assign add_const      = ctl.add_const;
  assign alu_sel        = ctl.alu_sel;
  assign cc_en          = ctl.cc_en;
  assign n              = ctl.nzp[2];
  assign z              = ctl.nzp[1];
  assign p              = ctl.nzp[0];
  assign const_n        = ctl.const_n;
  assign SEXT_Select    = ctl.sext_sel;
  assign halted         = ctl.halted;

endmodule
